// File: rtl/bcrypt_key_buffer_if.sv
// Byte-stream load and key-window read signals between bcrypt_key_buffer and its users.
// The master side is the password source plus the key-expansion consumer.
interface bcrypt_key_buffer_if;
  logic       load;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_last;
  logic [6:0] key_addr;
  logic [7:0] key_data [8];
  logic [6:0] key_len;
  logic       key_valid;
  logic       key_release;

  modport master (
    output load, in_valid, in_byte, in_last, key_addr, key_release,
    input  in_ready, key_data, key_len, key_valid
  );

  modport slave (
    input  load, in_valid, in_byte, in_last, key_addr, key_release,
    output in_ready, key_data, key_len, key_valid
  );
endinterface

// File: rtl/bcrypt_key_buffer.sv
// bcrypt key buffer: loads a NUL-terminated password and pre-expands it into a cyclic image.
// Optional macro KEYBUF_ZEROIZE_EN wipes the image on release before returning to IDLE.
module bcrypt_key_buffer #(
  parameter int MAX_KEY_BYTES = 72
) (
  input logic             clk,
  input logic             reset_l,
  bcrypt_key_buffer_if.slave bus
);

  localparam logic [6:0] MAX_LEN  = 7'(MAX_KEY_BYTES);
  localparam logic [6:0] LAST_IDX = 7'(MAX_KEY_BYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;
`ifdef KEYBUF_ZEROIZE_EN
  localparam logic [2:0] S_ZERO  = 3'd5;
`endif

  logic [2:0] state;
  logic [6:0] cnt;
  logic [6:0] src;
  logic [6:0] dst;
  logic [6:0] key_len;
  logic       key_valid;
  logic [7:0] image [MAX_KEY_BYTES];

  logic       img_we;
  logic [6:0] img_addr;
  logic [7:0] img_wdata;
  logic [7:0] win_addr [8];

  // Single image write port shared by load, terminator, cyclic fill and zeroize.
  always_comb begin
    img_we    = 1'b0;
    img_addr  = cnt;
    img_wdata = bus.in_byte;
    case (state)
      S_LOAD: begin
        img_we = bus.in_valid && (cnt < MAX_LEN);
      end
      S_TERM: begin
        img_we    = cnt < MAX_LEN;
        img_wdata = 8'h00;
      end
      S_FILL: begin
        img_we    = 1'b1;
        img_addr  = dst;
        img_wdata = image[src];
      end
`ifdef KEYBUF_ZEROIZE_EN
      S_ZERO: begin
        img_we    = 1'b1;
        img_addr  = dst;
        img_wdata = 8'h00;
      end
`endif
      default: begin
        img_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (img_we) begin
      image[img_addr] <= img_wdata;
    end
  end

  // key_valid is registered off READY, so it lags state entry by one cycle.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= S_IDLE;
      cnt       <= 7'd0;
      src       <= 7'd0;
      dst       <= 7'd0;
      key_len   <= 7'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            cnt   <= 7'd0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (cnt < MAX_LEN) begin
              cnt <= cnt + 7'd1;
            end
            if (bus.in_last) begin
              state <= S_TERM;
            end
          end
        end
        S_TERM: begin
          src <= 7'd0;
          if (cnt < MAX_LEN) begin
            key_len <= cnt + 7'd1;
            dst     <= cnt + 7'd1;
            state   <= ((cnt + 7'd1) < MAX_LEN) ? S_FILL : S_READY;
          end else begin
            key_len <= MAX_LEN;
            dst     <= MAX_LEN;
            state   <= S_READY;
          end
        end
        S_FILL: begin
          dst <= dst + 7'd1;
          src <= src + 7'd1;
          if (dst == LAST_IDX) begin
            state <= S_READY;
          end
        end
        S_READY: begin
          if (bus.key_release) begin
`ifdef KEYBUF_ZEROIZE_EN
            state   <= S_ZERO;
            dst     <= 7'd0;
            key_len <= 7'd0;
`else
            state <= S_IDLE;
`endif
          end else begin
            key_valid <= 1'b1;
          end
        end
`ifdef KEYBUF_ZEROIZE_EN
        S_ZERO: begin
          dst <= dst + 7'd1;
          if (dst == LAST_IDX) begin
            state <= S_IDLE;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Window addresses are formed at 8 bits so reads past the image end return zero instead of wrapping.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      win_addr[i]     = {1'b0, bus.key_addr} + 8'(i);
      bus.key_data[i] = 8'h00;
      if (key_valid && (win_addr[i] < {1'b0, MAX_LEN})) begin
        bus.key_data[i] = image[win_addr[i][6:0]];
      end
    end
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.key_len   = key_len;
  assign bus.key_valid = key_valid;

endmodule
